alu_result_fmt: RTL and testbench
=================================

# alu_result_fmt

Downstream formatter between the ALU result register and `uart_tx`. It captures each valid 8-bit ALU result with its zero and carry flags, then serialises it as a fixed ASCII frame of two uppercase hex digits, a space, two flag characters and an end-of-line. Each byte is handed to `uart_tx` through the existing `en_tx` / `tx_d_end` handshake. A one-entry pending buffer absorbs a result that arrives while a frame is in flight.

## Interface
- `EOL_LF`, default 1: 1 = frame ends CR LF (7 bytes); 0 = frame ends CR only (6 bytes).
- `TX_GAP`, default 0: idle cycles inserted after each `tx_d_end` before the next `en_tx`; range 0..255.

- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `res_val`  in  1  one-cycle strobe: result inputs valid this cycle.
- `res_data`  in  8  ALU result.
- `res_zero`  in  1  ALU zero flag.
- `res_cout`  in  1  ALU carry-out flag.
- `tx_d_end`  in  1  one-cycle pulse from `uart_tx`: current byte fully shifted out.
- `tx_data`  out  8  byte presented to `uart_tx`; registered.
- `en_tx`  out  1  one-cycle pulse: start transmitting `tx_data`.
- `busy`  out  1  frame in progress or pending entry valid.
- `res_ovr`  out  1  one-cycle pulse: a result was dropped.

## Operation
- Frame bytes, in order:
  - hex(`res_data[7:4]`)
  - hex(`res_data[3:0]`)
  - 0x20
  - `res_zero` ? 'Z' (0x5A) : '-' (0x2D)
  - `res_cout` ? 'C' (0x43) : '-'
  - 0x0D
  - 0x0A, only if `EOL_LF` = 1
- Hex mapping: 0–9 → 0x30–0x39; A–F → 0x41–0x46.
- Working register holds {data, zero, cout} for the current frame. The byte index counter runs 0..FRAME_LEN-1.
- Pending register: one entry plus a valid bit.
- FSM states:
  - IDLE → START on `res_val`, which latches the working register.
  - START: drive `tx_data` = byte[idx], pulse `en_tx`, go to WAIT.
  - WAIT: hold `tx_data`. On `tx_d_end`:
    - If not the last byte: idx+1, then GAP (TX_GAP>0) or START.
    - If the last byte: go to NEXT.
  - GAP: count TX_GAP cycles, then START.
  - NEXT:
    - Pending valid → move it to working, clear pending, idx=0, START.
    - Else if `res_val` is high this cycle → latch it, START.
    - Else → IDLE.
- `res_val` while not IDLE/NEXT:
  - Pending empty → capture into pending.
  - Pending full → drop the new result (pending is kept) and pulse `res_ovr` the next cycle.
- `tx_d_end` outside WAIT is ignored.
- Reset mid-frame: all state cleared immediately. No further `en_tx`; the partial frame is abandoned.

## Timing
- Reset values:
  - `tx_data` = 0x00, `en_tx` = 0, `busy` = 0, `res_ovr` = 0.
  - FSM = IDLE, idx = 0, pending invalid.
- From IDLE, `res_val` in cycle n → `en_tx` = 1 in cycle n+1, with `tx_data` = first hex char valid in the same cycle.
- `tx_data` is stable from the `en_tx` cycle until the cycle after the matching `tx_d_end`.
- `tx_d_end` in cycle m (non-last byte): next `en_tx` in cycle m+2+TX_GAP (WAIT→START costs one cycle, START registers the pulse).
- After the last byte's `tx_d_end` in cycle m: NEXT in m+1. A new frame's first `en_tx` is in m+3 if pending or a NEXT-cycle `res_val` is taken.
- `busy` = 1 from cycle n+1 until the cycle NEXT returns to IDLE; it is 0 in IDLE.
- `en_tx` is never high for two consecutive cycles and never high while a byte is outstanding.

## Test plan
- **Single frame.** Reset, then `res_val` with data 0x3A, zero=0, cout=1 → 7 `en_tx` pulses carrying 0x33, 0x41, 0x20, 0x2D, 0x43, 0x0D, 0x0A. `busy` falls after the last byte. `res_ovr` never pulses.
- **Flags and LF off.** With `EOL_LF` = 0: data 0x00, zero=1, cout=0 → 0x30, 0x30, 0x20, 0x5A, 0x2D, 0x0D; exactly 6 pulses.
- **Pending and overflow.** Send 0xF5 first. During the frame send 0x12, then 0x99 → 0xF5 frame, then 0x12 frame back-to-back. `res_ovr` pulses once (for 0x99); 0x99 is never transmitted.
- **Gap timing.** `TX_GAP` = 3, `uart_tx` model answers `tx_d_end` 10 cycles after each `en_tx` → intra-frame spacing between `en_tx` pulses is exactly 10+2+3 = 15 cycles.
- **Reset mid-frame.** Assert `reset` after the 3rd `tx_d_end` → next cycle all outputs are at reset values. A later `res_val` of 0x7C yields a clean frame starting 0x37, 0x43.
- **Spurious handshake.** `tx_d_end` pulses while IDLE or in START → ignored; no idx advance, no `en_tx`.

Source files
------------

// File: rtl/alu_result_fmt.sv
// alu_result_fmt: turns each captured ALU result into a short ASCII frame
// ("HH ZC\r\n") and feeds it byte by byte to uart_tx over en_tx / tx_d_end.
// A single pending slot holds one result that arrives mid-frame; a second
// one is dropped and flagged on res_ovr.
module alu_result_fmt #(
   parameter int EOL_LF = 1,
   parameter int TX_GAP = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       res_val,
   input  logic [7:0] res_data,
   input  logic       res_zero,
   input  logic       res_cout,
   input  logic       tx_d_end,
   output logic [7:0] tx_data,
   output logic       en_tx,
   output logic       busy,
   output logic       res_ovr
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] START = 3'd1;
   localparam logic [2:0] WAIT  = 3'd2;
   localparam logic [2:0] GAP   = 3'd3;
   localparam logic [2:0] NEXT  = 3'd4;

   // index of the final byte: LF is byte 6 when enabled, otherwise CR (5) ends it
   localparam logic [2:0] LAST_IDX = (EOL_LF != 0) ? 3'd6 : 3'd5;
   localparam logic [7:0] GAP_LAST = (TX_GAP > 0) ? 8'(TX_GAP - 1) : 8'd0;

   logic [2:0] state;
   logic [2:0] idx;
   logic [7:0] gap_cnt;
   logic [7:0] w_data;
   logic       w_zero;
   logic       w_cout;
   logic [7:0] p_data;
   logic       p_zero;
   logic       p_cout;
   logic       p_vld;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

   function automatic logic [7:0] frame_byte(input logic [2:0] i, input logic [7:0] d,
                                             input logic z, input logic c);
      logic [7:0] b;
      case (i)
         3'd0:    b = hex_char(d[7:4]);
         3'd1:    b = hex_char(d[3:0]);
         3'd2:    b = 8'h20;
         3'd3:    b = z ? 8'h5A : 8'h2D;
         3'd4:    b = c ? 8'h43 : 8'h2D;
         3'd5:    b = 8'h0D;
         default: b = 8'h0A;
      endcase
      return b;
   endfunction

   // the pending slot always drains in NEXT, so IDLE implies an empty slot
   assign busy = (state != IDLE) | p_vld;

   // frame sequencer, pending slot and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= 3'd0;
         gap_cnt <= 8'd0;
         w_data  <= 8'h00;
         w_zero  <= 1'b0;
         w_cout  <= 1'b0;
         p_data  <= 8'h00;
         p_zero  <= 1'b0;
         p_cout  <= 1'b0;
         p_vld   <= 1'b0;
         tx_data <= 8'h00;
         en_tx   <= 1'b0;
         res_ovr <= 1'b0;
      end else begin
         en_tx   <= 1'b0;
         res_ovr <= 1'b0;

         // results arriving mid-frame go to the pending slot or get dropped
         if (res_val && (state == START || state == WAIT || state == GAP)) begin
            if (!p_vld) begin
               p_data <= res_data;
               p_zero <= res_zero;
               p_cout <= res_cout;
               p_vld  <= 1'b1;
            end else begin
               res_ovr <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               // first byte goes out straight from the inputs so en_tx
               // follows res_val by one cycle; the START cycle is folded in
               if (res_val) begin
                  w_data  <= res_data;
                  w_zero  <= res_zero;
                  w_cout  <= res_cout;
                  idx     <= 3'd0;
                  tx_data <= hex_char(res_data[7:4]);
                  en_tx   <= 1'b1;
                  state   <= WAIT;
               end
            end
            START: begin
               tx_data <= frame_byte(idx, w_data, w_zero, w_cout);
               en_tx   <= 1'b1;
               state   <= WAIT;
            end
            WAIT: begin
               if (tx_d_end) begin
                  if (idx == LAST_IDX) begin
                     idx   <= 3'd0;
                     state <= NEXT;
                  end else begin
                     idx <= idx + 3'd1;
                     if (TX_GAP > 0) begin
                        gap_cnt <= 8'd0;
                        state   <= GAP;
                     end else begin
                        state <= START;
                     end
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) state <= START;
               else gap_cnt <= gap_cnt + 8'd1;
            end
            NEXT: begin
               idx <= 3'd0;
               if (p_vld) begin
                  w_data <= p_data;
                  w_zero <= p_zero;
                  w_cout <= p_cout;
                  state  <= START;
                  // the slot is being vacated, so a same-cycle result refills it
                  if (res_val) begin
                     p_data <= res_data;
                     p_zero <= res_zero;
                     p_cout <= res_cout;
                  end else begin
                     p_vld <= 1'b0;
                  end
               end else if (res_val) begin
                  w_data <= res_data;
                  w_zero <= res_zero;
                  w_cout <= res_cout;
                  state  <= START;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_result_fmt.sv
// Bench for alu_result_fmt: three instances (default, CR-only, TX_GAP=3),
// a uart_tx responder per instance, and a scoreboard monitor that pops the
// expected byte on every en_tx pulse.
module tb_alu_result_fmt;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [2:0] res_val, res_zero, res_cout, spur, resp_end, en_tx, busy, res_ovr;
   wire  [2:0] tx_d_end = resp_end | spur;
   logic [7:0] res_data [3];
   logic [7:0] tx_data  [3];

   alu_result_fmt #(.EOL_LF(1), .TX_GAP(0)) u_dflt (
      .clk(clk), .reset(rst), .res_val(res_val[0]), .res_data(res_data[0]),
      .res_zero(res_zero[0]), .res_cout(res_cout[0]), .tx_d_end(tx_d_end[0]),
      .tx_data(tx_data[0]), .en_tx(en_tx[0]), .busy(busy[0]), .res_ovr(res_ovr[0]));

   alu_result_fmt #(.EOL_LF(0), .TX_GAP(0)) u_cr (
      .clk(clk), .reset(rst), .res_val(res_val[1]), .res_data(res_data[1]),
      .res_zero(res_zero[1]), .res_cout(res_cout[1]), .tx_d_end(tx_d_end[1]),
      .tx_data(tx_data[1]), .en_tx(en_tx[1]), .busy(busy[1]), .res_ovr(res_ovr[1]));

   alu_result_fmt #(.EOL_LF(1), .TX_GAP(3)) u_gap (
      .clk(clk), .reset(rst), .res_val(res_val[2]), .res_data(res_data[2]),
      .res_zero(res_zero[2]), .res_cout(res_cout[2]), .tx_d_end(tx_d_end[2]),
      .tx_data(tx_data[2]), .en_tx(en_tx[2]), .busy(busy[2]), .res_ovr(res_ovr[2]));

   int         vecs = 0;
   int         miss = 0;
   logic [7:0] exp_q [3][$];
   int         cyc = 0;
   int         dly [3] = '{4, 4, 10};
   int         rcnt [3] = '{0, 0, 0};
   bit         dbl [3] = '{0, 0, 0};
   bit         extra [3] = '{0, 0, 0};
   int         ends [3] = '{0, 0, 0};
   int         npulse [3] = '{0, 0, 0};
   int         novr [3] = '{0, 0, 0};
   int         last_en [3] = '{0, 0, 0};
   int         fpos = 0;
   bit         prev_en [3] = '{0, 0, 0};

   task automatic chk(string nm, int act, int exp);
      vecs++;
      if (act != exp) begin
         miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // cycle counter for spacing checks
   always @(posedge clk) cyc <= cyc + 1;

   // uart_tx model: tx_d_end dly cycles after each en_tx, optionally doubled
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         resp_end[i] = 1'b0;
         if (rst) begin
            rcnt[i]  = 0;
            extra[i] = 1'b0;
         end else if (extra[i]) begin
            resp_end[i] = 1'b1;
            extra[i]    = 1'b0;
         end else if (en_tx[i]) begin
            rcnt[i] = dly[i];
         end else if (rcnt[i] > 0) begin
            rcnt[i]--;
            if (rcnt[i] == 0) begin
               resp_end[i] = 1'b1;
               extra[i]    = dbl[i];
               ends[i]++;
            end
         end
      end
   end

   // scoreboard monitor
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (en_tx[i]) begin
            npulse[i]++;
            chk("en_tx back-to-back", int'(prev_en[i]), 0);
            if (exp_q[i].size() == 0) begin
               vecs++;
               miss++;
               $display("FAIL unexpected en_tx on dut%0d: tx_data 0x%0h, none expected", i, tx_data[i]);
            end else begin
               chk($sformatf("tx_data dut%0d", i), int'(tx_data[i]), int'(exp_q[i].pop_front()));
            end
            if (i == 2) begin
               if (fpos > 0) chk("en_tx spacing with gap", cyc - last_en[i], 15);
               fpos = (fpos == 6) ? 0 : fpos + 1;
            end
            last_en[i] = cyc;
         end
         if (res_ovr[i]) novr[i]++;
         prev_en[i] = en_tx[i];
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic push(int i, logic [55:0] v, int n);
      for (int k = 0; k < n; k++) exp_q[i].push_back(v[55-8*k -: 8]);
   endtask

   task automatic send(int i, logic [7:0] d, logic z, logic c);
      res_val[i]  = 1'b1;
      res_data[i] = d;
      res_zero[i] = z;
      res_cout[i] = c;
      tick();
      res_val[i] = 1'b0;
   endtask

   task automatic wait_done(int i, string nm);
      int t = 0;
      while ((busy[i] || exp_q[i].size() != 0) && t < 3000) begin
         tick();
         t++;
      end
      chk({nm, " completes"}, int'(t < 3000), 1);
   endtask

   task automatic chk_reset_outs(int i, string nm);
      chk({nm, " tx_data"}, int'(tx_data[i]), 0);
      chk({nm, " en_tx"},   int'(en_tx[i]), 0);
      chk({nm, " busy"},    int'(busy[i]), 0);
      chk({nm, " res_ovr"}, int'(res_ovr[i]), 0);
   endtask

   initial begin
      int n0, e0, t;
      rst = 1'b1;
      res_val = '0; res_zero = '0; res_cout = '0; spur = '0;
      for (int i = 0; i < 3; i++) res_data[i] = 8'h00;
      repeat (3) tick();
      for (int i = 0; i < 3; i++) chk_reset_outs(i, $sformatf("reset dut%0d", i));
      rst = 1'b0;
      repeat (2) tick();

      // single frame 0x3A, Z=0, C=1
      push(0, 56'h33_41_20_2D_43_0D_0A, 7);
      send(0, 8'h3A, 1'b0, 1'b1);
      chk("first en_tx one cycle after res_val", int'(en_tx[0]), 1);
      chk("busy during frame", int'(busy[0]), 1);
      wait_done(0, "single frame");
      chk("single frame pulse count", npulse[0], 7);
      chk("single frame no overflow", novr[0], 0);

      // CR-only frame, zero flag set
      push(1, 56'h30_30_20_5A_2D_0D_00, 6);
      send(1, 8'h00, 1'b1, 1'b0);
      wait_done(1, "cr-only frame");
      repeat (5) tick();
      chk("cr-only pulse count", npulse[1], 6);

      // pending capture then overflow
      n0 = npulse[0];
      push(0, 56'h46_35_20_2D_2D_0D_0A, 7);
      push(0, 56'h31_32_20_2D_2D_0D_0A, 7);
      send(0, 8'hF5, 1'b0, 1'b0);
      repeat (5) tick();
      send(0, 8'h12, 1'b0, 1'b0);
      repeat (5) tick();
      send(0, 8'h99, 1'b1, 1'b1);
      chk("res_ovr pulse on drop", int'(res_ovr[0]), 1);
      tick();
      chk("res_ovr single cycle", int'(res_ovr[0]), 0);
      wait_done(0, "pending frames");
      chk("pending pulse count", npulse[0] - n0, 14);
      chk("overflow count", novr[0], 1);

      // gap timing
      push(2, 56'h35_42_20_2D_2D_0D_0A, 7);
      send(2, 8'h5B, 1'b0, 1'b0);
      wait_done(2, "gap frame");

      // reset mid-frame after the third tx_d_end
      n0 = npulse[0];
      e0 = ends[0];
      push(0, 56'h35_35_20_00_00_00_00, 3);
      send(0, 8'h55, 1'b0, 1'b0);
      t = 0;
      while (ends[0] - e0 < 3 && t < 200) begin
         tick();
         t++;
      end
      chk("third tx_d_end reached", int'(t < 200), 1);
      tick();
      rst = 1'b1;
      tick();
      chk_reset_outs(0, "mid-frame reset");
      tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("abandoned frame pulse count", npulse[0] - n0, 3);
      push(0, 56'h37_43_20_2D_2D_0D_0A, 7);
      send(0, 8'h7C, 1'b0, 1'b0);
      chk("post-reset first en_tx", int'(en_tx[0]), 1);
      wait_done(0, "post-reset frame");

      // spurious tx_d_end while idle, then in START via a doubled pulse
      n0 = npulse[0];
      spur[0] = 1'b1; tick(); spur[0] = 1'b0; tick();
      spur[0] = 1'b1; tick(); spur[0] = 1'b0;
      repeat (3) tick();
      chk("idle spurious busy", int'(busy[0]), 0);
      chk("idle spurious no en_tx", npulse[0] - n0, 0);
      dbl[0] = 1'b1;
      push(0, 56'h38_31_20_5A_43_0D_0A, 7);
      send(0, 8'h81, 1'b1, 1'b1);
      wait_done(0, "spurious-start frame");
      dbl[0] = 1'b0;
      repeat (5) tick();
      chk("spurious-start pulse count", npulse[0] - n0, 7);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end

endmodule
